vx_issue_perf_ctr: RTL

- Issue-stage performance counter engine; the producer behind the pipeline perf bundle's issue-side outputs.
- Watches ibuffer, scoreboard and dispatch handshakes each cycle, registers event flags, and accumulates stall-cycle counts and active-thread totals.
- Outputs feed the pipeline perf bundle, which the CSR unit reads.
- Instantiated once per core, inside the issue stage.

---
 rtl/vx_perf_pkg.sv | 27 ++
 rtl/vx_issue_perf_ctr_if.sv | 26 ++
 rtl/vx_perf_ctr.sv | 48 ++++
 rtl/vx_issue_perf_ctr.sv | 116 +++++++++++
 4 files changed

// File: rtl/vx_perf_pkg.sv
// Shared definitions for the issue-stage performance counters.
// Contents: execute-unit type codes, unit count, stage-1 stall flag layout,
// and the popcount result width helper.
package vx_perf_pkg;

  localparam int unsigned EX_TYPE_BITS = 3;
  localparam int unsigned NUM_UNITS    = 5;

  localparam logic [EX_TYPE_BITS-1:0] EX_ALU = 3'd0;
  localparam logic [EX_TYPE_BITS-1:0] EX_LSU = 3'd1;
  localparam logic [EX_TYPE_BITS-1:0] EX_CSR = 3'd2;
  localparam logic [EX_TYPE_BITS-1:0] EX_FPU = 3'd3;
  localparam logic [EX_TYPE_BITS-1:0] EX_GPU = 3'd4;

  // Registered single-cycle stall events; unit[t] is indexed by ex_type code.
  typedef struct packed {
    logic                 ibf;
    logic                 scb;
    logic [NUM_UNITS-1:0] unit;
  } stall_flags_t;

  // Bits needed to hold a popcount of n lanes (0..n inclusive).
  function automatic int unsigned popcnt_width(input int unsigned n);
    return int'($clog2(n + 1));
  endfunction

endpackage

// File: rtl/vx_issue_perf_ctr_if.sv
// Issue-stage handshake bundle observed by the perf counter engine.
// master: driven by the issue pipeline (or a bench driver).
// slave : observed by vx_issue_perf_ctr.
// Signals: ibuf/scb/disp valid+ready pairs, disp_ex_type (3b), disp_tmask (NUM_THREADS b).
interface vx_issue_perf_ctr_if #(
  parameter int unsigned NUM_THREADS = 4
);
  logic                   ibuf_valid;
  logic                   ibuf_ready;
  logic                   scb_valid;
  logic                   scb_ready;
  logic                   disp_valid;
  logic                   disp_ready;
  logic [2:0]             disp_ex_type;
  logic [NUM_THREADS-1:0] disp_tmask;

  modport master (
    output ibuf_valid, ibuf_ready, scb_valid, scb_ready,
           disp_valid, disp_ready, disp_ex_type, disp_tmask
  );

  modport slave (
    input  ibuf_valid, ibuf_ready, scb_valid, scb_ready,
           disp_valid, disp_ready, disp_ex_type, disp_tmask
  );
endinterface

// File: rtl/vx_perf_ctr.sv
// Single performance counter: adds inc every cycle, cleared by clear or reset.
// Build option: PERF_CTR_SATURATE_EN -> clamp at all-ones instead of wrapping.
// Ports: clk, reset (async, active-high), clear (sync), inc [INC_BITS],
//        value [CTR_BITS] (registered).
module vx_perf_ctr #(
  parameter int unsigned CTR_BITS = 44,
  parameter int unsigned INC_BITS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [INC_BITS-1:0] inc,
  output logic [CTR_BITS-1:0] value
);

  logic [CTR_BITS-1:0] r_value;
  logic [CTR_BITS-1:0] w_next;

`ifdef PERF_CTR_SATURATE_EN
  localparam int unsigned SUM_BITS = CTR_BITS + 1;
  logic [SUM_BITS-1:0] w_sum;

  // One extra bit catches the carry out; any carry means clamp.
  always_comb begin
    w_sum  = {1'b0, r_value} + SUM_BITS'(inc);
    w_next = w_sum[CTR_BITS] ? '1 : w_sum[CTR_BITS-1:0];
  end
`else
  // Plain modulo 2^CTR_BITS accumulate.
  always_comb begin
    w_next = r_value + CTR_BITS'(inc);
  end
`endif

  // Counter register; clear beats any increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
    end else if (clear) begin
      r_value <= '0;
    end else begin
      r_value <= w_next;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/vx_issue_perf_ctr.sv
// Issue-stage performance counter engine feeding the pipeline perf bundle.
// Stage 1 registers per-cycle stall flags and the dispatched thread count;
// stage 2 is a bank of eight vx_perf_ctr accumulators whose values are the outputs.
// Build option: PERF_CTR_SATURATE_EN (handled inside vx_perf_ctr).
// Ports: clk, reset (async, active-high), clear (sync),
//        perf_if (slave: ibuf/scb/disp handshakes, ex_type, tmask),
//        ibf/scb/alu/lsu/csr/fpu/gpu_stalls, active_threads [CTR_BITS].
module vx_issue_perf_ctr
  import vx_perf_pkg::*;
#(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned CTR_BITS    = 44
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  vx_issue_perf_ctr_if.slave  perf_if,
  output logic [CTR_BITS-1:0] ibf_stalls,
  output logic [CTR_BITS-1:0] scb_stalls,
  output logic [CTR_BITS-1:0] alu_stalls,
  output logic [CTR_BITS-1:0] lsu_stalls,
  output logic [CTR_BITS-1:0] csr_stalls,
  output logic [CTR_BITS-1:0] fpu_stalls,
  output logic [CTR_BITS-1:0] gpu_stalls,
  output logic [CTR_BITS-1:0] active_threads
);

  localparam int unsigned CNT_BITS = popcnt_width(NUM_THREADS);

  stall_flags_t        w_flags;
  stall_flags_t        r_flags;
  logic [CNT_BITS-1:0] w_popcnt;
  logic [CNT_BITS-1:0] w_fire_cnt;
  logic [CNT_BITS-1:0] r_fire_cnt;
  logic                w_disp_stall;
  logic                w_disp_fire;

  // Active lanes of the dispatched instruction.
  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < int'(NUM_THREADS); i++) begin
      w_popcnt = w_popcnt + CNT_BITS'(perf_if.disp_tmask[i]);
    end
  end

  // Stage-1 event decode; unknown ex_type codes match no unit.
  always_comb begin
    w_disp_stall = perf_if.disp_valid & ~perf_if.disp_ready;
    w_disp_fire  = perf_if.disp_valid &  perf_if.disp_ready;
    w_flags      = '0;
    w_flags.ibf  = perf_if.ibuf_valid & ~perf_if.ibuf_ready;
    w_flags.scb  = perf_if.scb_valid  & ~perf_if.scb_ready;
    for (int u = 0; u < int'(NUM_UNITS); u++) begin
      w_flags.unit[u] = w_disp_stall & (perf_if.disp_ex_type == EX_TYPE_BITS'(u));
    end
    w_fire_cnt = w_disp_fire ? w_popcnt : '0;
  end

  // Stage-1 flag register; clear drops events sampled on the clear cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags    <= '0;
      r_fire_cnt <= '0;
    end else if (clear) begin
      r_flags    <= '0;
      r_fire_cnt <= '0;
    end else begin
      r_flags    <= w_flags;
      r_fire_cnt <= w_fire_cnt;
    end
  end

  logic [CTR_BITS-1:0] w_unit_stalls [NUM_UNITS];

  // Stage-2 accumulators.
  vx_perf_ctr #(.CTR_BITS(CTR_BITS), .INC_BITS(1)) u_ibf_ctr (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (r_flags.ibf),
    .value (ibf_stalls)
  );

  vx_perf_ctr #(.CTR_BITS(CTR_BITS), .INC_BITS(1)) u_scb_ctr (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (r_flags.scb),
    .value (scb_stalls)
  );

  for (genvar u = 0; u < int'(NUM_UNITS); u++) begin : g_unit
    vx_perf_ctr #(.CTR_BITS(CTR_BITS), .INC_BITS(1)) u_unit_ctr (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .inc   (r_flags.unit[u]),
      .value (w_unit_stalls[u])
    );
  end

  vx_perf_ctr #(.CTR_BITS(CTR_BITS), .INC_BITS(CNT_BITS)) u_thr_ctr (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (r_fire_cnt),
    .value (active_threads)
  );

  assign alu_stalls = w_unit_stalls[EX_ALU];
  assign lsu_stalls = w_unit_stalls[EX_LSU];
  assign csr_stalls = w_unit_stalls[EX_CSR];
  assign fpu_stalls = w_unit_stalls[EX_FPU];
  assign gpu_stalls = w_unit_stalls[EX_GPU];

endmodule
